keypad_scanner: RTL and testbench

- Matrix keypad front end that sits directly upstream of the vending machine controller.
- Drives the 3x3 keypad columns one at a time and samples the rows.
- Resolves a single key per full scan, debounces it over several scans, and delivers a key code with a one-clock valid strobe.
- The downstream controller consumes only clean, single-shot key events.

---
 rtl/keypad_scanner.sv | 184 ++++++++++++++++++
 tb/tb_keypad_scanner.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// 3x3 matrix keypad scanner: column rotation, single-key resolution per scan,
// press/release debounce and a one-clock key strobe. KEY_REPEAT_EN adds auto-repeat while held.
module keypad_scanner #(
  parameter int SCAN_DIV       = 500,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int REPEAT_SCANS   = 50
) (
  input  logic       clock_in,
  input  logic       reset_in,
  input  logic [2:0] linha_in,
  output logic [2:0] coluna_out,
  output logic [3:0] tecla_out,
  output logic       valida_out
);

  localparam int DW   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int SMAX = (DEBOUNCE_SCANS > REPEAT_SCANS) ? DEBOUNCE_SCANS : REPEAT_SCANS;
  localparam int CW   = $clog2(SMAX + 1);

  typedef enum logic [1:0] {IDLE, CONFIRM, HELD, RELEASE} state_t;

  logic [DW-1:0] div_cnt;
  logic [1:0]    acc_n, base_n, samp_n;
  logic [3:0]    acc_code, base_code, samp_code;
  logic [1:0]    col_idx;
  logic          scan_end;
  logic [3:0]    raw;

  state_t        state, state_n;
  logic [3:0]    cand, cand_n, tecla_n;
  logic [CW-1:0] cnt, cnt_n, cnt_inc;
  logic          valida_n;
`ifdef KEY_REPEAT_EN
  logic [CW-1:0] rpt_cnt, rpt_n, rpt_inc;
`endif

  // Fold this column's rows into the running per-scan tally; column 0 starts a fresh scan.
  always_comb begin
    col_idx   = coluna_out[2] ? 2'd2 : (coluna_out[1] ? 2'd1 : 2'd0);
    base_n    = coluna_out[0] ? 2'd0 : acc_n;
    base_code = coluna_out[0] ? 4'd0 : acc_code;
    samp_n    = base_n;
    samp_code = base_code;
    for (int r = 0; r < 3; r++) begin
      if (linha_in[r]) begin
        if (samp_n != 2'd2) samp_n = samp_n + 2'd1;
        samp_code = 4'(r * 3) + {2'b00, col_idx} + 4'd1;
      end
    end
  end

  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      coluna_out <= 3'b001;
      div_cnt    <= '0;
      acc_n      <= '0;
      acc_code   <= '0;
      scan_end   <= 1'b0;
    end else begin
      scan_end <= 1'b0;
      if (div_cnt == DW'(SCAN_DIV - 1)) begin
        div_cnt    <= '0;
        coluna_out <= {coluna_out[1:0], coluna_out[2]};
        acc_n      <= samp_n;
        acc_code   <= samp_code;
        scan_end   <= coluna_out[2];
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end

  // Multi-key or ghosted scans collapse to "no key".
  assign raw     = (acc_n == 2'd1) ? acc_code : 4'd0;
  assign cnt_inc = (cnt == CW'(SMAX)) ? cnt : cnt + 1'b1;
`ifdef KEY_REPEAT_EN
  assign rpt_inc = (rpt_cnt == CW'(SMAX)) ? rpt_cnt : rpt_cnt + 1'b1;
`endif

  always_comb begin
    state_n  = state;
    cand_n   = cand;
    cnt_n    = cnt;
    tecla_n  = tecla_out;
    valida_n = 1'b0;
`ifdef KEY_REPEAT_EN
    rpt_n    = rpt_cnt;
`endif
    if (scan_end) begin
      case (state)
        IDLE: if (raw != 4'd0) begin
          cand_n = raw;
          if (DEBOUNCE_SCANS <= 1) begin
            tecla_n  = raw;
            valida_n = 1'b1;
            cnt_n    = '0;
            state_n  = HELD;
`ifdef KEY_REPEAT_EN
            rpt_n    = '0;
`endif
          end else begin
            cnt_n   = CW'(1);
            state_n = CONFIRM;
          end
        end
        CONFIRM: begin
          if (raw == 4'd0) begin
            cnt_n   = '0;
            state_n = IDLE;
          end else if (raw == cand) begin
            if (cnt_inc >= CW'(DEBOUNCE_SCANS)) begin
              tecla_n  = cand;
              valida_n = 1'b1;
              cnt_n    = '0;
              state_n  = HELD;
`ifdef KEY_REPEAT_EN
              rpt_n    = '0;
`endif
            end else begin
              cnt_n = cnt_inc;
            end
          end else begin
            cand_n = raw;
            cnt_n  = CW'(1);
          end
        end
        HELD: begin
          if (raw == 4'd0) begin
            cnt_n   = CW'(1);
            state_n = (DEBOUNCE_SCANS <= 1) ? IDLE : RELEASE;
`ifdef KEY_REPEAT_EN
            rpt_n   = '0;
          end else if (raw == cand) begin
            if (rpt_inc >= CW'(REPEAT_SCANS)) begin
              valida_n = 1'b1;
              rpt_n    = '0;
            end else begin
              rpt_n = rpt_inc;
            end
`endif
          end
        end
        RELEASE: begin
          if (raw != 4'd0) begin
            cnt_n   = '0;
            state_n = HELD;
`ifdef KEY_REPEAT_EN
            rpt_n   = '0;
`endif
          end else if (cnt_inc >= CW'(DEBOUNCE_SCANS)) begin
            cnt_n   = '0;
            state_n = IDLE;
          end else begin
            cnt_n = cnt_inc;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      state      <= IDLE;
      cand       <= '0;
      cnt        <= '0;
      tecla_out  <= '0;
      valida_out <= 1'b0;
`ifdef KEY_REPEAT_EN
      rpt_cnt    <= '0;
`endif
    end else begin
      state      <= state_n;
      cand       <= cand_n;
      cnt        <= cnt_n;
      tecla_out  <= tecla_n;
      valida_out <= valida_n;
`ifdef KEY_REPEAT_EN
      rpt_cnt    <= rpt_n;
`endif
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner: a keypad matrix model drives rows from the
// pressed-key mask and the scanned column; expected key codes are queued at press time.
module tb_keypad_scanner;

  logic       clk = 1'b0;
  logic       reset_in;
  logic [2:0] linha_in;
  logic [2:0] coluna_out;
  logic [3:0] tecla_out;
  logic       valida_out;

  logic [8:0] pressed = '0;   // bit k = key k+1, k = 3*row + col
  logic [3:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int pulse_cnt = 0;

  always #5 clk = ~clk;

  always_comb begin
    for (int r = 0; r < 3; r++) linha_in[r] = |(pressed[3*r +: 3] & coluna_out);
  end

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_SCANS(3), .REPEAT_SCANS(5)) dut (
    .clock_in(clk), .reset_in(reset_in), .linha_in(linha_in),
    .coluna_out(coluna_out), .tecla_out(tecla_out), .valida_out(valida_out)
  );

  // Pops the scoreboard on every strobe and checks its timing against the scan end.
  task automatic monitor();
    logic [2:0] pc;
    logic       pv;
    logic [3:0] e;
    int cyc, se;
    pc = 3'b001; pv = 1'b0; cyc = 0; se = -100;
    forever begin
      @(negedge clk);
      cyc++;
      if (pc == 3'b100 && coluna_out == 3'b001) se = cyc;
      if (valida_out === 1'b1) begin
        pulse_cnt++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_strobe: tecla=%0d, required no strobe", tecla_out);
        end else begin
          e = exp_q.pop_front();
          if (tecla_out !== e) begin
            errors++;
            $display("FAIL strobe_key: tecla=%0d, required %0d", tecla_out, e);
          end
        end
        checks++;
        if (cyc - se != 1) begin
          errors++;
          $display("FAIL strobe_latency: %0d clocks after scan end, required 1", cyc - se);
        end
        checks++;
        if (pv) begin
          errors++;
          $display("FAIL strobe_width: valida high on consecutive clocks, required single");
        end
      end
      pv = valida_out;
      pc = coluna_out;
    end
  endtask

  // Returns at the negedge right after the n-th scan end.
  task automatic wait_scans(input int n);
    int got;
    logic [2:0] p;
    got = 0;
    p = coluna_out;
    for (int i = 0; i < 2000 && got < n; i++) begin
      @(negedge clk);
      if (p == 3'b100 && coluna_out == 3'b001) got++;
      p = coluna_out;
    end
    checks++;
    if (got < n) begin
      errors++;
      $display("FAIL scan_timeout: saw %0d scan ends, required %0d", got, n);
    end
  endtask

  task automatic test_reset();
    reset_in = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    reset_in = 1'b0;
    checks++;
    if (coluna_out !== 3'b001) begin errors++; $display("FAIL reset_col: %b, required 001", coluna_out); end
    checks++;
    if (tecla_out !== 4'd0) begin errors++; $display("FAIL reset_tecla: %0d, required 0", tecla_out); end
    checks++;
    if (valida_out !== 1'b0) begin errors++; $display("FAIL reset_valida: %b, required 0", valida_out); end
    repeat (4) @(negedge clk);
    checks++;
    if (coluna_out !== 3'b010) begin errors++; $display("FAIL col_step1: %b, required 010", coluna_out); end
    repeat (4) @(negedge clk);
    checks++;
    if (coluna_out !== 3'b100) begin errors++; $display("FAIL col_step2: %b, required 100", coluna_out); end
    wait_scans(1);
  endtask

  task automatic test_single_press();
    int p0, extra;
    p0 = pulse_cnt;
`ifdef KEY_REPEAT_EN
    extra = 1;
    exp_q.push_back(4'd8);
`else
    extra = 0;
`endif
    exp_q.push_back(4'd8);
    pressed = 9'b1 << 7;
    wait_scans(2);
    checks++;
    if (pulse_cnt != p0) begin errors++; $display("FAIL press_early: %0d strobes, required 0", pulse_cnt - p0); end
    wait_scans(1);
    @(negedge clk); #1;
    checks++;
    if (pulse_cnt != p0 + 1) begin errors++; $display("FAIL press_on_time: %0d strobes, required 1", pulse_cnt - p0); end
    wait_scans(7);
    pressed = '0;
    wait_scans(4);
    checks++;
    if (pulse_cnt != p0 + 1 + extra) begin errors++; $display("FAIL press_count: %0d strobes, required %0d", pulse_cnt - p0, 1 + extra); end
    checks++;
    if (tecla_out !== 4'd8) begin errors++; $display("FAIL press_hold_code: %0d, required 8", tecla_out); end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL press_missing: %0d strobes outstanding, required 0", exp_q.size()); end
  endtask

  task automatic test_bounce();
    int p0;
    p0 = pulse_cnt;
    for (int i = 0; i < 6; i++) begin
      pressed = 9'b1;
      wait_scans(1);
      pressed = '0;
      wait_scans(1);
    end
    wait_scans(2);
    checks++;
    if (pulse_cnt != p0) begin errors++; $display("FAIL bounce_strobe: %0d strobes, required 0", pulse_cnt - p0); end
    checks++;
    if (tecla_out !== 4'd8) begin errors++; $display("FAIL bounce_code: %0d, required 8", tecla_out); end
  endtask

  task automatic test_multi_key();
    int p0;
    p0 = pulse_cnt;
    pressed = (9'b1 << 0) | (9'b1 << 5);
    wait_scans(10);
    checks++;
    if (pulse_cnt != p0) begin errors++; $display("FAIL multi_strobe: %0d strobes, required 0", pulse_cnt - p0); end
    exp_q.push_back(4'd6);
    pressed = 9'b1 << 5;
    wait_scans(2);
    checks++;
    if (pulse_cnt != p0) begin errors++; $display("FAIL single_early: %0d strobes, required 0", pulse_cnt - p0); end
    wait_scans(1);
    @(negedge clk); #1;
    checks++;
    if (pulse_cnt != p0 + 1) begin errors++; $display("FAIL single_on_time: %0d strobes, required 1", pulse_cnt - p0); end
    wait_scans(1);
    pressed = '0;
    wait_scans(4);
    checks++;
    if (tecla_out !== 4'd6) begin errors++; $display("FAIL single_code: %0d, required 6", tecla_out); end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL single_missing: %0d outstanding, required 0", exp_q.size()); end
  endtask

  task automatic test_back_to_back();
    int p0;
    p0 = pulse_cnt;
    exp_q.push_back(4'd5);
    pressed = 9'b1 << 4;
    wait_scans(4);
    checks++;
    if (pulse_cnt != p0 + 1) begin errors++; $display("FAIL key5_strobe: %0d strobes, required 1", pulse_cnt - p0); end
    pressed = pressed | (9'b1 << 8);
    wait_scans(4);
    checks++;
    if (pulse_cnt != p0 + 1) begin errors++; $display("FAIL key9_strobe: %0d strobes, required 1", pulse_cnt - p0); end
    checks++;
    if (tecla_out !== 4'd5) begin errors++; $display("FAIL key9_code: %0d, required 5", tecla_out); end
    pressed = '0;
    wait_scans(3);
    exp_q.push_back(4'd1);
    pressed = 9'b1;
    wait_scans(4);
    checks++;
    if (pulse_cnt != p0 + 2) begin errors++; $display("FAIL key1_strobe: %0d strobes, required 2", pulse_cnt - p0); end
    checks++;
    if (tecla_out !== 4'd1) begin errors++; $display("FAIL key1_code: %0d, required 1", tecla_out); end
    pressed = '0;
    wait_scans(4);
  endtask

  task automatic test_reset_mid_press();
    int p0;
    p0 = pulse_cnt;
    pressed = 9'b1 << 3;
    wait_scans(2);
    reset_in = 1'b1;
    @(negedge clk);
    checks++;
    if (tecla_out !== 4'd0) begin errors++; $display("FAIL midreset_tecla: %0d, required 0", tecla_out); end
    checks++;
    if (coluna_out !== 3'b001) begin errors++; $display("FAIL midreset_col: %b, required 001", coluna_out); end
    checks++;
    if (valida_out !== 1'b0) begin errors++; $display("FAIL midreset_valida: %b, required 0", valida_out); end
    pressed = '0;
    repeat (2) @(negedge clk);
    reset_in = 1'b0;
    wait_scans(4);
    checks++;
    if (pulse_cnt != p0) begin errors++; $display("FAIL midreset_strobe: %0d strobes, required 0", pulse_cnt - p0); end
    checks++;
    if (tecla_out !== 4'd0) begin errors++; $display("FAIL midreset_after: %0d, required 0", tecla_out); end
  endtask

  initial begin
    reset_in = 1'b1;
    fork
      monitor();
    join_none
    test_reset();
    test_single_press();
    test_bounce();
    test_multi_key();
    test_back_to_back();
    test_reset_mid_press();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
